// File: rtl/pipe_types_pkg.sv
// -----------------------------------------------------------------------------
// pipe_types_pkg
// Shared types and constants for the pipeline latch chain (pipe_stage_reg and
// its pipe_slot sub-module).
//   pipe_ctl_t     : per-slot control word {valid, halt}
//   PIPE_MAX_DEPTH : largest supported number of slots in one chain
//   PERF_CNT_W     : width of the optional performance counters
//   sat_inc()      : saturating increment used by the performance counters
// -----------------------------------------------------------------------------
package pipe_types_pkg;

  typedef struct packed {
    logic valid;
    logic halt;
  } pipe_ctl_t;

  localparam int PIPE_MAX_DEPTH = 8;
  localparam int PERF_CNT_W     = 32;

  // Stops at all-ones instead of wrapping back to zero.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One registered slot of the pipeline latch chain: a valid/halt control word
// plus an opaque payload. clear has priority over load; with neither the slot
// holds its contents.
// Ports:
//   CLK      in   rising-edge clock
//   nRST     in   asynchronous reset, active low (slot becomes a bubble)
//   clear    in   turn the slot into a bubble on this edge
//   load     in   capture in_ctl/in_data on this edge
//   in_ctl   in   incoming control word
//   in_data  in   incoming payload (DATA_W bits)
//   out_ctl  out  stored control word
//   out_data out  stored payload (DATA_W bits)
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_types_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              clear,
  input  logic              load,
  input  pipe_ctl_t         in_ctl,
  input  logic [DATA_W-1:0] in_data,
  output pipe_ctl_t         out_ctl,
  output logic [DATA_W-1:0] out_data
);

  // A bubble always carries RESET_VAL so downstream sees a known payload.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_ctl  <= '0;
      out_data <= RESET_VAL;
    end else if (clear) begin
      out_ctl  <= '0;
      out_data <= RESET_VAL;
    end else if (load) begin
      out_ctl  <= in_ctl;
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline latch chain carrying an opaque DATA_W payload through
// DEPTH registered slots, each with a valid and a halt bit. Supports global
// advance (en), stall hold, flush-to-bubble and a sticky halted flag that
// freezes the whole chain once a valid HALT has reached the last slot.
// Parameters:
//   DATA_W    payload width (>= 1)
//   DEPTH     number of slots in series (1..PIPE_MAX_DEPTH)
//   RESET_VAL payload of reset and bubble slots
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   en                 global advance qualifier
//   stall              hold every slot
//   flush              turn every slot into a bubble
//   in_valid, in_halt  incoming instruction is real / is HALT
//   in_data            incoming payload
//   out_valid/out_halt/out_data  contents of the last slot
//   halted             sticky flag, cleared only by nRST
// Optional feature macro PIPE_STAGE_PERF_EN adds:
//   stall_cnt, flush_cnt  saturating counters of stall and flush edges
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_types_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_halt,
  output logic [DATA_W-1:0] out_data,
  output logic              halted
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  pipe_ctl_t         slot_ctl  [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];
  pipe_ctl_t         head_ctl;
  logic              do_clear;
  logic              do_load;

  // Once halted nothing moves; flush outranks stall and en.
  assign do_clear = !halted && flush;
  assign do_load  = !halted && !flush && !stall && en;

  // A bubble entering the chain must never carry a halt marker.
  assign head_ctl = {in_valid, in_halt & in_valid};

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_ctl_t         ctl_d;
    logic [DATA_W-1:0] data_d;

    if (k == 0) begin : g_head
      assign ctl_d  = head_ctl;
      assign data_d = in_data;
    end else begin : g_tail
      assign ctl_d  = slot_ctl[k-1];
      assign data_d = slot_data[k-1];
    end

    pipe_slot #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .CLK      (CLK),
      .nRST     (nRST),
      .clear    (do_clear),
      .load     (do_load),
      .in_ctl   (ctl_d),
      .in_data  (data_d),
      .out_ctl  (slot_ctl[k]),
      .out_data (slot_data[k])
    );
  end

  assign out_valid = slot_ctl[DEPTH-1].valid;
  assign out_halt  = slot_ctl[DEPTH-1].halt;
  assign out_data  = slot_data[DEPTH-1];

  // Sticky halt: sets one edge after a valid HALT is visible at the output.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted <= 1'b0;
    end else if (out_valid && out_halt) begin
      halted <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counters share the priority of the slots: frozen while halted, and a
  // flush edge is never also counted as a stall edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!halted) begin
      if (flush) begin
        flush_cnt <= sat_inc(flush_cnt);
      end else if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives three pipe_stage_reg instances (DEPTH 1, 2, 3; the DEPTH=1 copy uses a
// non-zero RESET_VAL) from shared inputs. Directed scenarios compare against
// hand-derived constants; the random scenario compares every output against a
// reference model of the slot chain kept in this file.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam logic [31:0] RV1 = 32'hA5A5_5A5A;

  logic        clock = 1'b0;
  logic        nRst  = 1'b0;
  logic        en    = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inHalt  = 1'b0;
  logic [31:0] inData  = '0;

  logic        ov [3];
  logic        oh [3];
  logic [31:0] od [3];
  logic        hd [3];
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] sc [3];
  logic [31:0] fc [3];
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: slot k of instance i, slot 0 is the input end.
  int          dep [3] = '{1, 2, 3};
  logic [31:0] rv  [3] = '{RV1, 32'h0, 32'h0};
  logic        mv  [3][8];
  logic        mh  [3][8];
  logic [31:0] md  [3][8];
  logic        mhd [3];

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(32), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
    .CLK(clock), .nRST(nRst), .en(en), .stall(stall), .flush(flush),
    .in_valid(inValid), .in_halt(inHalt), .in_data(inData),
    .out_valid(ov[0]), .out_halt(oh[0]), .out_data(od[0]), .halted(hd[0])
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .DEPTH(2), .RESET_VAL(32'h0)) dut2 (
    .CLK(clock), .nRST(nRst), .en(en), .stall(stall), .flush(flush),
    .in_valid(inValid), .in_halt(inHalt), .in_data(inData),
    .out_valid(ov[1]), .out_halt(oh[1]), .out_data(od[1]), .halted(hd[1])
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .DEPTH(3), .RESET_VAL(32'h0)) dut3 (
    .CLK(clock), .nRST(nRst), .en(en), .stall(stall), .flush(flush),
    .in_valid(inValid), .in_halt(inHalt), .in_data(inData),
    .out_valid(ov[2]), .out_halt(oh[2]), .out_data(od[2]), .halted(hd[2])
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc[2]), .flush_cnt(fc[2])
`endif
  );

  task automatic applyStimulus(input logic v, input logic h, input logic [31:0] d,
                               input logic e, input logic s, input logic f);
    inValid = v;
    inHalt  = h;
    inData  = d;
    en      = e;
    stall   = s;
    flush   = f;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mhd[i] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        mv[i][k] = 1'b0;
        mh[i][k] = 1'b0;
        md[i][k] = rv[i];
      end
    end
  endtask

  // One clock edge of the behavioural rules, using the inputs held before it.
  task automatic modelEdge();
    for (int i = 0; i < 3; i++) begin
      if (!mhd[i]) begin
        logic haltSeen;
        haltSeen = mv[i][dep[i]-1] & mh[i][dep[i]-1];
        if (flush) begin
          for (int k = 0; k < dep[i]; k++) begin
            mv[i][k] = 1'b0;
            mh[i][k] = 1'b0;
            md[i][k] = rv[i];
          end
        end else if (en && !stall) begin
          for (int k = dep[i] - 1; k > 0; k--) begin
            mv[i][k] = mv[i][k-1];
            mh[i][k] = mh[i][k-1];
            md[i][k] = md[i][k-1];
          end
          mv[i][0] = inValid;
          mh[i][0] = inHalt & inValid;
          md[i][0] = inData;
        end
        if (haltSeen) mhd[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (nRst) modelEdge();
    #1;
  endtask

  task automatic test_reset();
    nRst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    modelReset();
    repeat (3) tick();
    #2;
    nRst = 1'b0;
    #1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      checks += 3;
      if (ov[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_valid d%0d: got %b expected 0", dep[i], ov[i]);
      end
      if (od[i] !== rv[i]) begin
        failures++;
        $display("[TB] FAIL reset_data d%0d: got %h expected %h", dep[i], od[i], rv[i]);
      end
      if (hd[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_halted d%0d: got %b expected 0", dep[i], hd[i]);
      end
    end
    tick();
    checks++;
    if (ov[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_held d3: got %b expected 0", ov[2]);
    end
  endtask

  task automatic test_latency();
    logic [31:0] expData [6] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h0};
    logic        expValid [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    nRst = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t < 3) applyStimulus(1'b1, 1'b0, 32'(t + 1), 1'b1, 1'b0, 1'b0);
      else       applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checks += 2;
      if (ov[2] !== expValid[t]) begin
        failures++;
        $display("[TB] FAIL latency_valid edge%0d: got %b expected %b", t + 1, ov[2], expValid[t]);
      end
      if (od[2] !== expData[t]) begin
        failures++;
        $display("[TB] FAIL latency_data edge%0d: got %h expected %h", t + 1, od[2], expData[t]);
      end
    end
    // Changing in_* between edges must not reach the outputs, even at DEPTH=1.
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    tick();
    inData = 32'hCAFE_F00D;
    #2;
    checks++;
    if (od[0] !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL no_comb_path d1: got %h expected 12345678", od[0]);
    end
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 1'b0, 32'd6, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd5, 1'b1, 1'b0, 1'b0);
    tick();
    for (int t = 0; t < 6; t++) begin
      if (t < 4) applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 1'b1, 1'b0);
      else       applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
      tick();
      checks += 2;
      if (ov[1] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hold_valid edge%0d: got %b expected 1", t, ov[1]);
      end
      if (od[1] !== 32'd6) begin
        failures++;
        $display("[TB] FAIL hold_data edge%0d: got %h expected 6", t, od[1]);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (od[1] !== 32'd5) begin
      failures++;
      $display("[TB] FAIL hold_slot0: got %h expected 5", od[1]);
    end
  endtask

  task automatic test_flush_beats_stall();
    for (int t = 0; t < 3; t++) begin
      applyStimulus(1'b1, 1'b0, 32'(11 + t), 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h7777_7777, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (ov[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL flush_valid d%0d: got %b expected 0", dep[i], ov[i]);
      end
      if (od[i] !== rv[i]) begin
        failures++;
        $display("[TB] FAIL flush_data d%0d: got %h expected %h", dep[i], od[i], rv[i]);
      end
    end
    // Drain: every interior slot must also have become a bubble.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (ov[2] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL flush_drain edge%0d: got %b expected 0", t, ov[2]);
      end
    end
  endtask

  task automatic test_sticky_halt();
    nRst = 1'b0;
    #1;
    modelReset();
    nRst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'd8, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd9, 1'b1, 1'b0, 1'b0);
    tick();
    checks += 2;
    if (oh[1] !== 1'b1 || ov[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL halt_arrive: got valid=%b halt=%b expected 1 1", ov[1], oh[1]);
    end
    if (hd[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_early: got %b expected 0", hd[1]);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (hd[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL halt_set: got %b expected 1", hd[1]);
    end
    for (int t = 0; t < 4; t++) begin
      if (t == 0) applyStimulus(1'b1, 1'b0, 32'h4444, 1'b1, 1'b0, 1'b1);
      else        applyStimulus(1'b1, 1'b0, 32'(100 + t), 1'b1, 1'b0, 1'b0);
      tick();
      checks += 2;
      if (ov[1] !== 1'b1 || oh[1] !== 1'b1 || od[1] !== 32'd8) begin
        failures++;
        $display("[TB] FAIL halt_frozen edge%0d: got v=%b h=%b d=%h expected 1 1 8", t, ov[1], oh[1], od[1]);
      end
      if (hd[1] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL halt_sticky edge%0d: got %b expected 1", t, hd[1]);
      end
    end
    nRst = 1'b0;
    #1;
    modelReset();
    checks++;
    if (hd[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_clear: got %b expected 0", hd[1]);
    end
    nRst = 1'b1;
  endtask

  task automatic test_random();
    nRst = 1'b0;
    #1;
    modelReset();
    nRst = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 60 == 59) begin
        nRst = 1'b0;
        #2;
        modelReset();
        nRst = 1'b1;
      end
      applyStimulus(($urandom % 4) != 0, ($urandom % 10) == 0, $urandom,
                    ($urandom % 5) != 0, ($urandom % 4) == 0, ($urandom % 12) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks += 4;
        if (ov[i] !== mv[i][dep[i]-1]) begin
          failures++;
          $display("[TB] FAIL rand_valid d%0d cyc%0d: got %b expected %b", dep[i], cyc, ov[i], mv[i][dep[i]-1]);
        end
        if (oh[i] !== mh[i][dep[i]-1]) begin
          failures++;
          $display("[TB] FAIL rand_halt d%0d cyc%0d: got %b expected %b", dep[i], cyc, oh[i], mh[i][dep[i]-1]);
        end
        if (od[i] !== md[i][dep[i]-1]) begin
          failures++;
          $display("[TB] FAIL rand_data d%0d cyc%0d: got %h expected %h", dep[i], cyc, od[i], md[i][dep[i]-1]);
        end
        if (hd[i] !== mhd[i]) begin
          failures++;
          $display("[TB] FAIL rand_halted d%0d cyc%0d: got %b expected %b", dep[i], cyc, hd[i], mhd[i]);
        end
      end
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    nRst = 1'b0;
    #1;
    modelReset();
    nRst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 32'h1, 1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    checks += 2;
    if (sc[1] !== 32'd3) begin
      failures++;
      $display("[TB] FAIL perf_stall: got %0d expected 3", sc[1]);
    end
    if (fc[1] !== 32'd2) begin
      failures++;
      $display("[TB] FAIL perf_flush: got %0d expected 2", fc[1]);
    end
    force dut2.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut2.stall_cnt;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    checks++;
    if (sc[1] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL perf_saturate: got %h expected ffffffff", sc[1]);
    end
  endtask
`endif

  initial begin
    $display("[TB] start");
    modelReset();
    #3;
    test_reset();
    test_latency();
    test_hold();
    test_flush_beats_stall();
    test_sticky_halt();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
